// File: rtl/udma_tx_sched_pkg.sv
// Shared types and helpers for the uDMA TX L2 read-request scheduler.
package udma_tx_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BEAT_BYTES         = DEFAULT_DATA_WIDTH / 8;

  // Next beat address; the caller truncates to its L2 width, which gives the wrap.
  function automatic logic [31:0] addr_incr(input logic [31:0] addr, input int data_width);
    return addr + 32'(data_width / 8);
  endfunction

endpackage

// File: rtl/udma_rr_arb.sv
// Round-robin arbiter with a hold-while-ungranted lock; owns the rotating pointer.
module udma_rr_arb
  import udma_tx_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [N-1:0]         req_i,
  input  logic                 lock_i,
  input  logic [$clog2(N)-1:0] lock_idx_i,
  input  logic                 adv_i,
  output logic [N-1:0]         sel_oh_o,
  output logic [$clog2(N)-1:0] sel_idx_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] lidx_q;
  logic          lock_q;
  logic          lock_hit;
  logic          found;
  logic [IW-1:0] cand;

  // A lock only holds while the locked requester is still asking.
  assign lock_hit = lock_q & req_i[lidx_q];

  always_comb begin
    sel_idx_o = '0;
    sel_oh_o  = '0;
    found     = 1'b0;
    cand      = '0;
    if (lock_hit) begin
      sel_idx_o = lidx_q;
      found     = 1'b1;
    end else begin
      for (int o = 0; o < N; o++) begin
        cand = IW'((int'(ptr_q) + o) % N);
        if (!found && req_i[cand]) begin
          found     = 1'b1;
          sel_idx_o = cand;
        end
      end
    end
    if (found) sel_oh_o[sel_idx_o] = 1'b1;
  end

  assign ptr_d = (sel_idx_o == IW'(N - 1)) ? '0 : sel_idx_o + 1'b1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q  <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
    end else if (adv_i) begin
      ptr_q  <= ptr_d;
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_i;
      if (lock_i) lidx_q <= lock_idx_i;
    end
  end

endmodule

// File: rtl/udma_tx_sched.sv
// Shares one L2 read-request port among N_CH TX channels; tracks per-channel address/count and marks.
module udma_tx_sched
  import udma_tx_sched_pkg::*;
#(
  parameter int N_CH             = 4,
  parameter int L2_AWIDTH        = 18,
  parameter int DATA_WIDTH       = 32,
  parameter int TRANS_SIZE_WIDTH = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rstn_i,
  input  logic [N_CH-1:0]                        cfg_start_i,
  input  logic [N_CH-1:0][L2_AWIDTH-1:0]         cfg_addr_i,
  input  logic [N_CH-1:0][TRANS_SIZE_WIDTH-1:0]  cfg_size_i,
  input  logic [N_CH-1:0]                        cfg_clr_i,
  output logic [N_CH-1:0]                        busy_o,
  output logic [N_CH-1:0]                        done_o,
  input  logic [N_CH-1:0]                        ch_req_i,
  output logic [N_CH-1:0]                        ch_gnt_o,
  output logic [N_CH-1:0]                        ch_sof_o,
  output logic [N_CH-1:0]                        ch_eof_o,
  output logic                                   l2_req_o,
  output logic [L2_AWIDTH-1:0]                   l2_addr_o,
  input  logic                                   l2_gnt_i
);

  localparam int IW = $clog2(N_CH);

  logic [N_CH-1:0]                elig;
  logic [N_CH-1:0]                ch_first;
  logic [N_CH-1:0]                ch_last;
  logic [N_CH-1:0]                sel_oh;
  logic [IW-1:0]                  sel_idx;
  logic [N_CH-1:0][L2_AWIDTH-1:0] ch_addr;
  logic                           l2_fire;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_e                   state_q, state_d;
    logic [L2_AWIDTH-1:0]        addr_q, addr_d;
    logic [TRANS_SIZE_WIDTH-1:0] left_q, left_d;
    logic                        first_q, first_d;
    logic                        done_q, done_d;

    // Clear wins over start and grant; a grant in the clear cycle leaves no trace here.
    always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      left_d  = left_q;
      first_d = first_q;
      done_d  = 1'b0;
      if (cfg_clr_i[i]) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (cfg_start_i[i] && (cfg_size_i[i] != '0)) begin
              state_d = RUN;
              addr_d  = cfg_addr_i[i];
              left_d  = cfg_size_i[i];
              first_d = 1'b1;
            end
          end
          RUN: begin
            if (ch_gnt_o[i]) begin
              addr_d  = L2_AWIDTH'(addr_incr(32'(addr_q), DATA_WIDTH));
              left_d  = left_q - 1'b1;
              first_d = 1'b0;
              if (left_q == TRANS_SIZE_WIDTH'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        state_q <= IDLE;
        first_q <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        first_q <= first_d;
        done_q  <= done_d;
      end
    end

    always_ff @(posedge clk_i) begin
      addr_q <= addr_d;
      left_q <= left_d;
    end

    assign busy_o[i]   = (state_q == RUN);
    assign done_o[i]   = done_q;
    assign elig[i]     = (state_q == RUN) & ch_req_i[i];
    assign ch_addr[i]  = addr_q;
    assign ch_first[i] = first_q;
    assign ch_last[i]  = (left_q == TRANS_SIZE_WIDTH'(1));
  end

  udma_rr_arb #(
    .N (N_CH)
  ) u_arb (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .req_i      (elig),
    .lock_i     (l2_req_o & ~l2_gnt_i),
    .lock_idx_i (sel_idx),
    .adv_i      (l2_fire),
    .sel_oh_o   (sel_oh),
    .sel_idx_o  (sel_idx)
  );

  // Grant path is purely combinational so the FIFO sees gnt in its request cycle.
  assign l2_req_o  = |elig;
  assign l2_fire   = l2_req_o & l2_gnt_i;
  assign ch_gnt_o  = sel_oh & {N_CH{l2_fire}};
  assign ch_sof_o  = ch_gnt_o & ch_first;
  assign ch_eof_o  = ch_gnt_o & ch_last;
  assign l2_addr_o = l2_req_o ? ch_addr[sel_idx] : '0;

endmodule

// File: tb/tb_udma_tx_sched.sv
// Directed bench for udma_tx_sched: expected grants go to a scoreboard, a negedge monitor checks them.
module tb_udma_tx_sched;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [3:0]       cfg_start = '0;
  logic [3:0][17:0] cfg_addr = '0;
  logic [3:0][15:0] cfg_size = '0;
  logic [3:0]       cfg_clr = '0;
  logic [3:0]       busy, done;
  logic [3:0]       ch_req = '0;
  logic [3:0]       ch_gnt, ch_sof, ch_eof;
  logic             l2_req;
  logic [17:0]      l2_addr;
  logic             l2_gnt = 1'b0;

  int tests = 0;
  int fails = 0;
  int beat_no = 0;

  typedef struct {
    int          ch;
    logic [17:0] addr;
    logic        sof;
    logic        eof;
  } beat_t;

  beat_t sb[$];

  udma_tx_sched #(
    .N_CH (4), .L2_AWIDTH (18), .DATA_WIDTH (32), .TRANS_SIZE_WIDTH (16)
  ) dut (
    .clk_i (clk), .rstn_i (rstn),
    .cfg_start_i (cfg_start), .cfg_addr_i (cfg_addr), .cfg_size_i (cfg_size),
    .cfg_clr_i (cfg_clr), .busy_o (busy), .done_o (done),
    .ch_req_i (ch_req), .ch_gnt_o (ch_gnt), .ch_sof_o (ch_sof), .ch_eof_o (ch_eof),
    .l2_req_o (l2_req), .l2_addr_o (l2_addr), .l2_gnt_i (l2_gnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [17:0] addr, input logic sof, input logic eof);
    beat_t b;
    b.ch = ch; b.addr = addr; b.sof = sof; b.eof = eof;
    sb.push_back(b);
  endtask

  task automatic set_ch(input int ch, input logic [17:0] addr, input logic [15:0] size);
    cfg_addr[ch] = addr;
    cfg_size[ch] = size;
    cfg_start[ch] = 1'b1;
  endtask

  task automatic idle_inputs();
    cfg_start = '0; cfg_clr = '0; ch_req = '0; l2_gnt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ch_req = 4'hF;
    rstn = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_gnt", 32'({ch_gnt, ch_sof, ch_eof}), 32'h0);
    check("rst_l2", 32'({l2_req, l2_addr}), 32'h0);
    tick();
    rstn = 1'b1;
    ch_req = '0;
    tick();
  endtask

  // Scoreboard monitor: every cycle that presents a grant consumes one expected beat.
  always @(negedge clk) begin
    beat_t      e;
    logic [3:0] eg, es, ee;
    if (rstn && (ch_gnt != 4'h0)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_grant: gnt=%b addr=%h, expected no grant", ch_gnt, l2_addr);
      end else begin
        e  = sb.pop_front();
        eg = 4'b0001 << e.ch;
        es = e.sof ? eg : 4'h0;
        ee = e.eof ? eg : 4'h0;
        if ({ch_gnt, ch_sof, ch_eof, l2_addr} !== {eg, es, ee, e.addr}) begin
          fails++;
          $display("FAIL beat%0d: gnt=%b sof=%b eof=%b addr=%h, expected gnt=%b sof=%b eof=%b addr=%h",
                   beat_no, ch_gnt, ch_sof, ch_eof, l2_addr, eg, es, ee, e.addr);
        end
      end
      beat_no++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single channel, three beats back to back.
    push(0, 18'h00100, 1'b1, 1'b0);
    push(0, 18'h00104, 1'b0, 1'b0);
    push(0, 18'h00108, 1'b0, 1'b1);
    ch_req = 4'hF; l2_gnt = 1'b1;
    set_ch(0, 18'h00100, 16'd3);
    tick(); cfg_start = '0;
    check("single_busy", 32'(busy), 32'h1);
    tick(); tick(); tick();
    check("single_done", 32'(done), 32'h1);
    check("single_idle", 32'(busy), 32'h0);
    tick();
    check("single_done_pulse", 32'(done), 32'h0);

    // Size 1 then size 0.
    push(1, 18'h02000, 1'b1, 1'b1);
    set_ch(1, 18'h02000, 16'd1);
    tick(); cfg_start = '0;
    check("size1_busy", 32'(busy), 32'h2);
    tick();
    check("size1_done", 32'(done), 32'h2);
    set_ch(2, 18'h03000, 16'd0);
    tick(); cfg_start = '0;
    check("size0_busy", 32'(busy), 32'h0);
    check("size0_req", 32'(l2_req), 32'h0);
    tick();
    check("size0_done", 32'(done), 32'h0);

    // Fairness: four channels of four beats each.
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++)
        push(c, 18'(32'h1000 * (c + 1) + 4 * k), k == 0, k == 3);
    ch_req = 4'hF; l2_gnt = 1'b1;
    for (int c = 0; c < 4; c++) set_ch(c, 18'(32'h1000 * (c + 1)), 16'd4);
    tick(); cfg_start = '0;
    check("fair_busy", 32'(busy), 32'hF);
    for (int n = 0; n < 16; n++) tick();
    check("fair_done3", 32'(done), 32'h8);
    check("fair_idle", 32'(busy), 32'h0);
    idle_inputs();

    // Backpressure: ch1 locked while ch0/ch2 become eligible.
    do_reset();
    push(1, 18'h00500, 1'b1, 1'b0);
    push(2, 18'h00900, 1'b1, 1'b1);
    push(0, 18'h00300, 1'b1, 1'b1);
    push(1, 18'h00504, 1'b0, 1'b1);
    set_ch(0, 18'h00300, 16'd1);
    set_ch(1, 18'h00500, 16'd2);
    set_ch(2, 18'h00900, 16'd1);
    ch_req = 4'b0010;
    tick(); cfg_start = '0;
    check("bp_req", 32'(l2_req), 32'h1);
    check("bp_addr_c1", 32'(l2_addr), 32'h500);
    tick();
    ch_req = 4'b0111; #1;
    check("bp_addr_c2", 32'(l2_addr), 32'h500);
    tick();
    check("bp_addr_c3", 32'(l2_addr), 32'h500);
    tick();
    l2_gnt = 1'b1;
    tick(); tick(); tick(); tick();
    check("bp_drained", 32'({l2_req, busy}), 32'h0);
    idle_inputs();

    // Withdrawal releases the lock.
    do_reset();
    push(2, 18'h00900, 1'b1, 1'b1);
    push(1, 18'h00500, 1'b1, 1'b1);
    set_ch(1, 18'h00500, 16'd1);
    set_ch(2, 18'h00900, 16'd1);
    ch_req = 4'b0110;
    tick(); cfg_start = '0;
    check("wd_addr_c1", 32'(l2_addr), 32'h500);
    tick();
    ch_req = 4'b0100; #1;
    check("wd_addr_c2", 32'(l2_addr), 32'h900);
    l2_gnt = 1'b1;
    tick();
    ch_req = 4'b0010;
    tick();
    idle_inputs();
    tick();
    check("wd_idle", 32'(busy), 32'h0);

    // Clear mid-transfer, then restart.
    do_reset();
    push(0, 18'h00040, 1'b1, 1'b0);
    push(0, 18'h00044, 1'b0, 1'b0);
    push(0, 18'h00048, 1'b0, 1'b0);
    push(0, 18'h00080, 1'b1, 1'b1);
    ch_req = 4'b0001; l2_gnt = 1'b1;
    set_ch(0, 18'h00040, 16'd4);
    tick(); cfg_start = '0;
    tick();
    tick();
    cfg_clr = 4'b0001;
    tick(); cfg_clr = '0;
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_req", 32'(l2_req), 32'h0);
    check("clr_done", 32'(done), 32'h0);
    tick();
    check("clr_done_late", 32'(done), 32'h0);
    set_ch(0, 18'h00080, 16'd1);
    tick(); cfg_start = '0;
    tick();
    check("restart_done", 32'(done), 32'h1);

    // Address wrap.
    push(3, 18'h3FFFC, 1'b1, 1'b0);
    push(3, 18'h00000, 1'b0, 1'b1);
    ch_req = 4'b1000;
    set_ch(3, 18'h3FFFC, 16'd2);
    tick(); cfg_start = '0;
    tick(); tick();
    check("wrap_done", 32'(done), 32'h8);
    idle_inputs();
    tick(); tick();

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udma_tx_sched.md
# udma_tx_sched

Round-robin scheduler that shares one L2 read-request port among N_CH uDMA TX channels. Each channel's TX mark FIFO raises a request whenever it has room for another in-flight beat. The scheduler:
- grants one channel per accepted L2 request;
- generates the channel's incrementing L2 address;
- counts the channel's remaining beats;
- drives the FIFO's sof/eof mark strobes on the first and last granted beat.

It sits between the per-channel configuration registers and the L2 interconnect.

## Interface
- N_CH, 4, number of TX channels (2..16)
- L2_AWIDTH, 18, L2 byte-address width
- DATA_WIDTH, 32, beat width in bits; address stride is DATA_WIDTH/8
- TRANS_SIZE_WIDTH, 16, transfer length width, in beats
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_start_i  in  N_CH  per-channel start pulse
- cfg_addr_i  in  N_CH×L2_AWIDTH  start byte address, sampled on start
- cfg_size_i  in  N_CH×TRANS_SIZE_WIDTH  length in beats, sampled on start
- cfg_clr_i  in  N_CH  per-channel abort
- busy_o  out  N_CH  channel in RUN
- done_o  out  N_CH  one-cycle pulse after the last beat is granted
- ch_req_i  in  N_CH  request from the channel FIFO
- ch_gnt_o  out  N_CH  grant to the channel FIFO
- ch_sof_o  out  N_CH  start-of-frame mark to the FIFO, coincident with grant
- ch_eof_o  out  N_CH  end-of-frame mark to the FIFO, coincident with grant
- l2_req_o  out  1  L2 read request
- l2_addr_o  out  L2_AWIDTH  L2 byte address
- l2_gnt_i  in  1  L2 grant

## Operation
- **Per-channel FSM, IDLE→RUN:**
  - Taken on cfg_start_i with cfg_size_i≠0.
  - Loads r_addr=cfg_addr_i, r_left=cfg_size_i, r_first=1.
  - A start with size 0 is ignored.
  - A start in RUN is ignored.
- **Per-channel FSM, RUN→IDLE:**
  - Taken on the grant where r_left==1; done_o pulses the next cycle.
  - Also taken on cfg_clr_i, with no done_o pulse.
  - cfg_clr_i has priority over a simultaneous start or grant.
- **Eligibility:** channel i is eligible when it is in RUN and ch_req_i[i]=1.
- **Request and address:**
  - l2_req_o = OR of eligible channels.
  - l2_addr_o = r_addr of the selected channel; 0 when there is no request.
- **Arbitration:** round-robin from pointer r_ptr.
  - Selected = first eligible channel at or after r_ptr, wrapping modulo N_CH.
  - After a grant to channel k, r_ptr←(k+1) mod N_CH.
- **Lock:** when l2_req_o=1 and l2_gnt_i=0, the selection is locked to that channel for the following cycles.
  - The lock holds while that channel stays eligible, so the address stays stable.
  - The lock releases on grant, or when the locked channel withdraws its request or is cleared. Arbitration then restarts from r_ptr.
- **Grant outputs:** ch_gnt_o[sel] = l2_gnt_i & l2_req_o, combinational; at most one bit is set.
- **Marks:**
  - ch_sof_o[sel] = ch_gnt_o[sel] & r_first.
  - ch_eof_o[sel] = ch_gnt_o[sel] & (r_left==1).
  - Size 1: sof and eof are asserted on the same grant.
- **On a grant:**
  - r_addr += DATA_WIDTH/8, wrapping modulo 2^L2_AWIDTH.
  - r_left −= 1.
  - r_first←0.
- **Restart:** a channel may restart in the cycle after done_o.

## Timing
- **Reset values:**
  - All FSMs IDLE; r_ptr=0; lock cleared.
  - busy_o, done_o, ch_gnt_o, ch_sof_o, ch_eof_o, l2_req_o = 0; l2_addr_o = 0.
- **Latency:**
  - start → busy_o: 1 cycle.
  - start → first possible l2_req_o: 1 cycle.
- **Grant path:** l2_gnt_i → ch_gnt_o/sof/eof is 0-cycle combinational. This is required because the FIFO's in-flight accounting samples gnt in the same cycle as req.
- **Throughput:** one beat per cycle aggregate when l2_gnt_i is held high.
- **Fairness:** with all N_CH channels continuously eligible, grants cycle 0,1,..,N_CH−1,0.
- **Clear mid-transfer:**
  - busy_o falls the next cycle.
  - No further grants go to the cleared channel.
  - A grant coinciding with the clear is still delivered to the FIFO, but the address and count updates are discarded.

## Structure
- **Package udma_tx_sched_pkg:**
  - ch_state_e {IDLE, RUN}.
  - BEAT_BYTES = DATA_WIDTH/8.
  - Helper function computing the address increment.
- **Sub-module udma_rr_arb (N parameter):**
  - Inputs: req vector, lock, lock index, advance.
  - Outputs: one-hot select plus index.
  - Owns r_ptr and the lock register.
- **Top level:** per-channel state registers in a generate loop.

## Test plan
- **Single channel:** ch0, addr 0x100, size 3, gnt tied 1 → grants at consecutive cycles with addr 0x100/0x104/0x108, sof on the 1st, eof on the 3rd, done_o one cycle later.
- **Size 1 / size 0:**
  - Size 1 at 0x2000 → one grant with sof=eof=1.
  - Size 0 → busy_o stays 0, no request.
- **Fairness:** 4 channels, size 4 each, all req high, gnt=1 → grant order 0,1,2,3 ×4, each channel's eof on its 4th grant.
- **Backpressure:**
  - gnt held 0 for 3 cycles while ch1 is selected and ch2 becomes eligible → addr stays at ch1's value, the eventual grant goes to ch1, then ch2.
  - Same setup, ch1 drops req while ungranted → selection moves to ch2.
- **Clear:** cfg_clr_i on ch0 mid-transfer (2 beats left) → busy_o 0 next cycle, no done_o, no further ch0 grants; a restart then begins with sof.
- **Wrap:** L2_AWIDTH=18, addr 0x3FFFC, size 2 → addresses 0x3FFFC then 0x00000.
